// File: rtl/game_judge.sv
// Round referee: tracks score, lives and the round countdown for the game FSM,
// raises registered won/lost levels and pulses hud_update on any HUD change.
module game_judge #(
  parameter int unsigned SCORE_TARGET = 10,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned TIME_LIMIT   = 60,
  parameter int unsigned CLK_HZ       = 25_000_000,
  parameter int unsigned HIT_GUARD    = 50_000_000
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [1:0] state,
  input  logic       collect_evt,
  input  logic       hit_evt,
  output logic       game_won,
  output logic       game_over,
  output logic [7:0] score,
  output logic [3:0] lives,
  output logic [7:0] time_left,
  output logic       hud_update
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned GW = (HIT_GUARD > 0) ? $clog2(HIT_GUARD + 1) : 1;

  localparam logic [PW-1:0] PRE_TC    = PW'(CLK_HZ - 1);
  localparam logic [GW-1:0] GUARD_LD  = GW'(HIT_GUARD);
  localparam logic [7:0]    SCORE_WIN = 8'(SCORE_TARGET);
  localparam logic [3:0]    LIVES_LD  = 4'(LIVES_INIT);
  localparam logic [7:0]    TIME_LD   = 8'(TIME_LIMIT);

  typedef enum logic [1:0] {
    GAME_START = 2'b00,
    IN_GAME    = 2'b01,
    GAME_OVER  = 2'b10,
    GAME_WON   = 2'b11
  } game_fsm_t;

  typedef enum logic [1:0] {
    ARMED,
    PLAY,
    DONE_WON,
    DONE_LOST
  } judge_st_t;

  game_fsm_t game_st;
  judge_st_t cur_st, nxt_st;

  logic [7:0]    score_n, time_n;
  logic [3:0]    lives_n;
  logic          won_n, over_n, hud_n, reload;
  logic [PW-1:0] pre_cnt, pre_n;
  logic [GW-1:0] guard_cnt, guard_n;

  assign game_st = game_fsm_t'(state);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cur_st     <= ARMED;
      score      <= '0;
      lives      <= LIVES_LD;
      time_left  <= TIME_LD;
      game_won   <= 1'b0;
      game_over  <= 1'b0;
      hud_update <= 1'b0;
      pre_cnt    <= '0;
      guard_cnt  <= '0;
    end else begin
      cur_st     <= nxt_st;
      score      <= score_n;
      lives      <= lives_n;
      time_left  <= time_n;
      game_won   <= won_n;
      game_over  <= over_n;
      hud_update <= hud_n;
      pre_cnt    <= pre_n;
      guard_cnt  <= guard_n;
    end
  end

  always_comb begin
    nxt_st  = cur_st;
    score_n = score;
    lives_n = lives;
    time_n  = time_left;
    won_n   = game_won;
    over_n  = game_over;
    hud_n   = 1'b0;
    pre_n   = pre_cnt;
    guard_n = guard_cnt;
    reload  = 1'b0;

    case (cur_st)
      ARMED: begin
        reload = 1'b1;
        if (game_st == IN_GAME) nxt_st = PLAY;
      end

      PLAY: begin
        // Any FSM state other than IN_GAME here is an abort: flags are only
        // ever raised on the same edge that leaves PLAY.
        if (game_st != IN_GAME) begin
          reload = 1'b1;
          hud_n  = 1'b1;
          nxt_st = ARMED;
        end else begin
          if (collect_evt) score_n = score + 8'd1;

          if (guard_cnt != '0) begin
            guard_n = guard_cnt - 1'b1;
          end else if (hit_evt && lives != '0) begin
            lives_n = lives - 4'd1;
            guard_n = GUARD_LD;
          end

          if (pre_cnt == PRE_TC) begin
            pre_n = '0;
            if (time_left != '0) time_n = time_left - 8'd1;
          end else begin
            pre_n = pre_cnt + 1'b1;
          end

          if (score_n == SCORE_WIN) begin
            nxt_st = DONE_WON;
            won_n  = 1'b1;
          end else if (lives_n == '0 || time_n == '0) begin
            nxt_st = DONE_LOST;
            over_n = 1'b1;
          end

          hud_n = (score_n != score) || (lives_n != lives) || (time_n != time_left);
        end
      end

      DONE_WON, DONE_LOST: begin
        pre_n   = '0;
        guard_n = '0;
        if (game_st == GAME_START) begin
          reload = 1'b1;
          hud_n  = 1'b1;
          nxt_st = ARMED;
        end
      end

      default: nxt_st = ARMED;
    endcase

    if (reload) begin
      score_n = '0;
      lives_n = LIVES_LD;
      time_n  = TIME_LD;
      won_n   = 1'b0;
      over_n  = 1'b0;
      pre_n   = '0;
      guard_n = '0;
    end
  end

endmodule
